// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared FSM state enum, parameter defaults and fetch-buffer entry type
package fetch_sequencer_pkg;
  typedef enum logic {BOOT, RUN} state_e;
  localparam logic [31:0] BOOT_ADDR_DEF = 32'h0000_0000;
  localparam int FIFO_DEPTH_DEF = 2;
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        upper;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: i$ bus (mem_req/addr/gnt/rvalid/rdata) and realigner bus (fetch_valid/data/addr/upper/ready); master = sequencer
interface fetch_sequencer_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_data_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_upper_o;
  logic        fetch_ready_i;
  modport master (
    output mem_req_o, mem_addr_o, fetch_valid_o, fetch_data_o, fetch_addr_o, fetch_upper_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, fetch_ready_i
  );
  modport slave (
    input  mem_req_o, mem_addr_o, fetch_valid_o, fetch_data_o, fetch_addr_o, fetch_upper_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, fetch_ready_i
  );
endinterface

// File: rtl/fetch_sequencer_fifo.sv
// fetch_fifo: shift-style entry FIFO (clk_i, rst_ni, clr_i, push_i, pop_i, din_i -> valid_o, head_o, cnt_o); head holds its last value when empty
module fetch_fifo
  import fetch_sequencer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  fetch_entry_t                 din_i,
  output logic                         valid_o,
  output fetch_entry_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   cnt_o
);
  localparam int CW = $clog2(DEPTH+1);
  fetch_entry_t q [DEPTH];
  fetch_entry_t q_d [DEPTH];
  logic [CW-1:0] cnt, rem;
  logic pop;
  assign pop = pop_i && cnt != '0;
  assign rem = cnt - CW'(pop);
  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    fetch_entry_t shifted;
    if (k + 1 < DEPTH) begin : g_mid
      assign shifted = pop ? q[k+1] : q[k];
    end else begin : g_last
      assign shifted = q[k];
    end
    assign q_d[k] = CW'(k) < rem ? shifted : (push_i && CW'(k) == rem) ? din_i : q[k];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      cnt <= clr_i ? '0 : cnt + CW'(push_i) - CW'(pop);
      if (!clr_i) for (int i = 0; i < DEPTH; i++) q[i] <= q_d[i];
    end
  end
  assign valid_o = cnt != '0;
  assign head_o = q[0];
  assign cnt_o = cnt;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: i$ fetch sequencer (clk_i, rst_ni, flush_i, redirect_addr_i; bus.master = i$ request/response + realigner buffer head)
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = BOOT_ADDR_DEF,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [31:0]        redirect_addr_i,
  fetch_sequencer_if.master  bus
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int SW = CW + 1;
  state_e state_q, state_d;
  logic [31:0] addr_q, rsp_addr_q, redir;
  logic [CW-1:0] out_q, out_d, disc_q, fifo_cnt;
  logic pend_q, req, grant, dec, push, pop, fifo_valid;
  fetch_entry_t head;
  assign redir = {redirect_addr_i[31:2], 2'b00};
  always_comb begin
    state_d = state_q == BOOT ? RUN : state_q;
    req = state_q == RUN && !flush_i && SW'(out_q) + SW'(fifo_cnt) < SW'(FIFO_DEPTH);
  end
  assign grant = req && bus.mem_gnt_i;
  assign dec = bus.mem_rvalid_i && out_q != '0;
  assign out_d = out_q + CW'(grant) - CW'(dec);
  // responses still owed to a pre-flush request are dropped before anything is buffered
  assign push = dec && disc_q == '0 && !flush_i;
  assign pop = fifo_valid && bus.fetch_ready_i && !flush_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      addr_q <= BOOT_ADDR;
      rsp_addr_q <= BOOT_ADDR;
      out_q <= '0;
      disc_q <= '0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      if (flush_i) begin
        addr_q <= redir;
        rsp_addr_q <= redir;
        disc_q <= out_d;
        pend_q <= redirect_addr_i[1];
      end else begin
        if (grant) addr_q <= addr_q + 32'd4;
        if (push) rsp_addr_q <= rsp_addr_q + 32'd4;
        if (push) pend_q <= 1'b0;
        if (dec && disc_q != '0) disc_q <= disc_q - 1'b1;
      end
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .push_i (push),
    .pop_i  (pop),
    .din_i  ('{data: bus.mem_rdata_i, addr: rsp_addr_q, upper: pend_q}),
    .valid_o(fifo_valid),
    .head_o (head),
    .cnt_o  (fifo_cnt)
  );
  assign bus.mem_req_o = req;
  assign bus.mem_addr_o = {addr_q[31:2], 2'b00};
  assign bus.fetch_valid_o = fifo_valid;
  assign bus.fetch_data_o = head.data;
  assign bus.fetch_addr_o = head.addr;
  assign bus.fetch_upper_o = head.upper;
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter BOOT_ADDR, 32'h0000_0000, word-aligned address of the first fetch after reset.
REQ-002 Parameter FIFO_DEPTH, 2, fetch-buffer entries; also the bound on outstanding plus buffered words.
REQ-003 clk_i  in  1  single subsystem clock; all state updates on the rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 flush_i  in  1  controller redirect request, sampled on the rising edge.
REQ-006 redirect_addr_i  in  32  redirect target; bit 1 selects the half-word, bit 0 ignored.
REQ-007 mem_req_o  out  1  i$ fetch request.
REQ-008 mem_addr_o  out  32  word-aligned fetch address; bits [1:0] always 2'b00.
REQ-009 mem_gnt_i  in  1  i$ accepts the request in this cycle.
REQ-010 mem_rvalid_i  in  1  i$ returns one 32-bit block; responses arrive in order, 1 or more cycles after grant.
REQ-011 mem_rdata_i  in  32  returned block.
REQ-012 fetch_valid_o  out  1  buffer head holds a valid block for the realigner.
REQ-013 fetch_data_o  out  32  buffer head block.
REQ-014 fetch_addr_o  out  32  word address of the buffer head block.
REQ-015 fetch_upper_o  out  1  head block is the first block after a redirect to an odd half-word (redirect_addr_i[1]=1).
REQ-016 fetch_ready_i  in  1  realigner consumes the head block; it is driven low while the realigner stalls the PC.

Function
REQ-017 FSM states: BOOT, RUN. BOOT exists for exactly one cycle after reset release, then the FSM enters RUN; mem_req_o is 0 in BOOT.
REQ-018 In RUN, mem_req_o = 1 when (outstanding + buffer count) < FIFO_DEPTH and flush_i = 0.
REQ-019 mem_addr_o holds while mem_req_o is asserted and not granted (no address change without a grant).
REQ-020 On mem_req_o & mem_gnt_i, the fetch address increments by 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0) and the outstanding count increments.
REQ-021 On mem_rvalid_i, the outstanding count decrements. If the discard count is 0, the block and its address are written to the buffer tail; otherwise the block is dropped and the discard count decrements.
REQ-022 Pop happens when fetch_valid_o & fetch_ready_i. A push and a pop in the same cycle are both performed. Push while full cannot occur, by REQ-018.
REQ-023 fetch_valid_o = buffer not empty. When empty, fetch_data_o, fetch_addr_o and fetch_upper_o hold their last value.
REQ-024 Latency: first request 1 cycle after reset release; a block reaches fetch_valid_o the cycle after its mem_rvalid_i (registered buffer).
REQ-025 Flush: the next cycle, the buffer is empty and the fetch address = {redirect_addr_i[31:2], 2'b00}.
REQ-026 On flush, discard count = outstanding after this cycle's grant/rvalid. A request granted in the flush cycle and in-flight responses are all discarded. An rvalid in the flush cycle is dropped and is not counted.
REQ-027 On flush, a pending-upper flag is set from redirect_addr_i[1]. It is attached as fetch_upper_o to the first block pushed after the flush, then cleared.
REQ-028 Flush has priority over push, pop and the pending-upper attachment in the same cycle. Back-to-back flushes each reload the address and recompute the discard count.
REQ-029 Counter widths are $clog2(FIFO_DEPTH+1); the outstanding and discard counts never underflow.

Reset
REQ-030 While rst_ni = 0, the following values are forced asynchronously:
- state = BOOT
- fetch address = BOOT_ADDR
- outstanding, discard and buffer counts = 0
- pending-upper = 0
- mem_req_o = 0, fetch_valid_o = 0, fetch_upper_o = 0
- fetch_data_o = 0, fetch_addr_o = 0
REQ-031 Reset mid-transaction abandons all in-flight responses; the i$ is reset in the same domain.

Structure
REQ-032 The shared fetch package holds:
- the FSM state enum
- the BOOT_ADDR default
- the FIFO_DEPTH default
REQ-033 One sub-module, fetch_fifo: parameterised synchronous FIFO with data+address+flag entries and a clear input driven by flush.

Verification
REQ-034 Reset release, gnt=1, rvalid 1 cycle later, data sequence A,B,C -> requests at 0x0, 0x4, 0x8; fetch_data_o A,B,C with fetch_addr_o 0x0, 0x4, 0x8.
REQ-035 fetch_ready_i=0 held for 10 cycles -> exactly 2 requests issued, mem_req_o then stays 0 until a pop.
REQ-036 Two outstanding requests, flush with target 0x100 -> next address 0x100; both stale responses dropped; first valid block has address 0x100 and fetch_upper_o=0.
REQ-037 Flush to 0x206 in the same cycle as mem_rvalid_i -> that response dropped; request at 0x204; first block has fetch_upper_o=1, the next has 0.
REQ-038 Address 0xFFFF_FFFC granted -> next request at 0x0000_0000.
REQ-039 rst_ni low while 2 requests are outstanding -> all outputs reset immediately; after release, the first request is at BOOT_ADDR with no spurious fetch_valid_o.
